// File: rtl/bcd_seq_converter_pkg.sv
// bcd_pkg: shared state encoding, constants and sizing helper for bcd_seq_converter.
package bcd_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK      = 4'hF;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    function automatic int cnt_width(input int bin_width);
        return $clog2(bin_width + 1);
    endfunction
endpackage

// File: rtl/bcd_seq_converter_add3_cell.sv
// bcd_add3_cell: one double-dabble digit correction, adds 3 to a digit of 5 or more.
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= ADD3_THRESHOLD) ? i_digit + 4'd3 : i_digit;
endmodule

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential binary-to-BCD (double dabble), one shift per clock.
// Define BCD_SEQ_LZB_EN to blank leading zero digits (4'hF) in bcd_out.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 8,
    parameter int DIGITS    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  ready,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = cnt_width(BIN_WIDTH);

    generate
        if (BIN_WIDTH < 1 || BIN_WIDTH > 32 || DIGITS < 1 || DIGITS > 10) begin : g_bad_params
            $fatal(1, "bcd_seq_converter: illegal BIN_WIDTH/DIGITS");
        end
    endgenerate

    state_t                r_state;
    logic [BIN_WIDTH-1:0]  r_bin;
    logic [BW-1:0]         r_bcd;
    logic                  r_ovf;
    logic [CW-1:0]         r_cnt;
    logic                  r_valid;
    logic [BW-1:0]         r_bcd_out;
    logic                  r_ovf_out;

    logic [BW-1:0]         w_adj;
    logic [BW-1:0]         w_bcd_sh;
    logic                  w_ovf_sh;
    logic [BW-1:0]         w_bcd_fmt;

    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_cell
            bcd_add3_cell u_cell (
                .i_digit (r_bcd[4*d +: 4]),
                .o_digit (w_adj[4*d +: 4])
            );
        end
    endgenerate

    // The bit pushed out of the top digit would land in a digit we do not have.
    assign w_bcd_sh = {w_adj[BW-2:0], r_bin[BIN_WIDTH-1]};
    assign w_ovf_sh = r_ovf | w_adj[BW-1];

`ifdef BCD_SEQ_LZB_EN
    always_comb begin
        logic lead;
        w_bcd_fmt = w_bcd_sh;
        lead      = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lead = lead && (w_bcd_sh[4*i +: 4] == 4'd0);
            if (lead) w_bcd_fmt[4*i +: 4] = BCD_BLANK;
        end
    end
`else
    assign w_bcd_fmt = w_bcd_sh;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_bcd_out <= '0;
            r_ovf_out <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin   <= bin_in;
                        r_bcd   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= CW'(BIN_WIDTH);
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bin <= r_bin << 1;
                    r_bcd <= w_bcd_sh;
                    r_ovf <= w_ovf_sh;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_bcd_out <= w_bcd_fmt;
                        r_ovf_out <= w_ovf_sh;
                        r_valid   <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready    = (r_state == ST_IDLE);
    assign valid    = r_valid;
    assign bcd_out  = r_bcd_out;
    assign overflow = r_ovf_out;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: directed + random checks of two converters (3 and 2 digits) against a decimal model.
module tb_bcd_seq_converter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] bin_in = '0;
    logic         ready, valid, overflow;
    logic [11:0]  bcd_out;
    logic         ready2, valid2, overflow2;
    logic [7:0]   bcd_out2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bcd_seq_converter #(.BIN_WIDTH(W), .DIGITS(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .ready(ready), .valid(valid), .bcd_out(bcd_out), .overflow(overflow)
    );

    bcd_seq_converter #(.BIN_WIDTH(W), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .ready(ready2), .valid(valid2), .bcd_out(bcd_out2), .overflow(overflow2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decimal digits by division, then optional leading-zero blanking.
    function automatic logic [63:0] model_bcd(input int unsigned v, input int d);
        logic [63:0] r;
        int unsigned t;
        bit lead;
        r = '0;
        t = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
`ifdef BCD_SEQ_LZB_EN
        lead = 1'b1;
        for (int i = d - 1; i > 0; i--) begin
            if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`else
        lead = 1'b0;
`endif
        return r;
    endfunction

    task automatic check_result(input string tag, input int unsigned v);
        chk({tag, "_bcd3"}, 64'(bcd_out), model_bcd(v, 3));
        chk({tag, "_ovf3"}, 64'(overflow), 64'(v >= 1000));
        chk({tag, "_bcd2"}, 64'(bcd_out2), model_bcd(v, 2));
        chk({tag, "_ovf2"}, 64'(overflow2), 64'(v >= 100));
        chk({tag, "_valid2"}, 64'(valid2), 64'(1));
    endtask

    task automatic convert(input string tag, input int unsigned v, input bit pulse);
        int lat;
        int c;
        @(negedge clk);
        c = 0;
        while (!ready && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_ready_wait"}, 64'(ready), 64'(1));
        start  = 1'b1;
        bin_in = W'(v);
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = W'($urandom);
        chk({tag, "_busy"}, 64'(ready), 64'(0));
        lat = -1;
        for (int k = 1; k <= W + 4; k++) begin
            if (pulse) start = (k == 3 || k == W);
            @(posedge clk);
            #1;
            if (valid) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(W));
        check_result(tag, v);
        @(posedge clk);
        #1;
        chk({tag, "_valid_fall"}, 64'(valid), 64'(0));
        chk({tag, "_ready_rise"}, 64'(ready), 64'(1));
    endtask

    initial begin
        int v1;
        int v2;
        int n;
        #2;
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_bcd", 64'(bcd_out), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        convert("d255", 255, 1'b0);
        convert("d0", 0, 1'b0);
        convert("d9", 9, 1'b0);
        convert("d100", 100, 1'b1);
        convert("d99", 99, 1'b0);
        convert("d5", 5, 1'b1);

        // Start held high: back-to-back conversions, second samples the new operand.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd37;
        @(posedge clk);
        #1;
        bin_in = 8'd200;
        v1 = -1;
        v2 = -1;
        n  = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) start = 1'b0;
            if (valid) begin
                n++;
                if (v1 < 0) begin
                    v1 = k;
                    check_result("b2b_first", 37);
                end else begin
                    v2 = k;
                    check_result("b2b_second", 200);
                end
            end
        end
        chk("b2b_first_at", 64'(v1), 64'(8));
        chk("b2b_second_at", 64'(v2), 64'(18));
        chk("b2b_count", 64'(n), 64'(2));

        // Reset after three shifts discards the conversion.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd123;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(ready), 64'(1));
        chk("mid_rst_valid", 64'(valid), 64'(0));
        chk("mid_rst_bcd", 64'(bcd_out), 64'(0));
        chk("mid_rst_ovf", 64'(overflow2), 64'(0));
        chk("mid_rst_bcd2", 64'(bcd_out2), 64'(0));
        n = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid) n++;
        end
        chk("mid_rst_no_valid", 64'(n), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        convert("after_rst", 123, 1'b0);

        for (int i = 0; i < 30; i++)
            convert("rand", $urandom_range(0, 255), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
